proc_control: RTL

Instruction-sequencing control unit for the general-purpose processor. It captures a 9-bit instruction from `DIN` and steps through time steps T0–T3. In each step it drives the one-hot register read/write enables, the ALU operand and result strobes, and the bus-source selects. Register selects use the same one-hot encoding as the processor's 3-to-8 register decoders.

---
 rtl/proc_control.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/proc_control.sv
// ---------------------------------------------------------------------------
// proc_control
//
// Instruction-sequencing control unit for a small general-purpose processor.
// An instruction word is captured from DIN while the unit is idle (T0) and a
// request is present on Run. The unit then walks through time steps T1..T3.
// In each step it raises the register, ALU and bus strobes that the selected
// opcode needs.
//
// Instruction format: {op[8:6], Rx[5:3], Ry[2:0]}
//   000 mv  Rx,Ry   T1: Rout=Ry, Rin=Rx, Done
//   001 mvi Rx,#D   T1: DINout, Rin=Rx, Done (D is DIN during T1)
//   010 add Rx,Ry   T1: Rout=Rx, Ain | T2: Rout=Ry, Gin | T3: Gout, Rin=Rx, Done
//   011 sub Rx,Ry   as add, with AddSub=1 in T2
//   1xx reserved    T1: Done only (no-op)
//
// Register selects are one-hot with R0 on bit 7 and R7 on bit 0. This
// matches the processor's 3-to-8 register decoders.
//
// Ports
//   Clock   in  1  rising-edge clock
//   Reset   in  1  synchronous, active-high; also blanks every output
//   Run     in  1  start request, sampled only in T0
//   DIN     in  9  instruction word / immediate data
//   IR      out 9  registered instruction being executed
//   IRin    out 1  instruction-register load strobe
//   Rin     out 8  one-hot register write enable
//   Rout    out 8  one-hot register bus-drive select
//   Ain     out 1  load ALU operand register A
//   Gin     out 1  load ALU result register G
//   Gout    out 1  G drives the bus
//   DINout  out 1  DIN drives the bus
//   AddSub  out 1  ALU operation, 0 = add, 1 = subtract
//   Done    out 1  final step of the instruction
// ---------------------------------------------------------------------------
module proc_control (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] DIN,
    output logic [8:0] IR,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_t;

    step_t      r_step;
    step_t      w_step_next;
    logic [8:0] r_ir;

    logic [2:0] w_op;
    logic [7:0] w_rx_oh;
    logic [7:0] w_ry_oh;

    // Decoded control before the reset blanking is applied.
    logic       w_irin;
    logic [7:0] w_rin;
    logic [7:0] w_rout;
    logic       w_ain;
    logic       w_gin;
    logic       w_gout;
    logic       w_dinout;
    logic       w_addsub;
    logic       w_done;

    // Register n maps to bit (7-n).
    function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
        return 8'b1000_0000 >> idx;
    endfunction

    assign w_op    = r_ir[8:6];
    assign w_rx_oh = reg_onehot(r_ir[5:3]);
    assign w_ry_oh = reg_onehot(r_ir[2:0]);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            r_step <= w_step_next;
            if (w_irin) begin
                r_ir <= DIN;
            end
        end
    end

    always_comb begin
        w_irin   = 1'b0;
        w_rin    = '0;
        w_rout   = '0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_gout   = 1'b0;
        w_dinout = 1'b0;
        w_addsub = 1'b0;
        w_done   = 1'b0;

        unique case (r_step)
            T0: begin
                w_irin = Run;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout = w_ry_oh;
                        w_rin  = w_rx_oh;
                        w_done = 1'b1;
                    end
                    OP_MVI: begin
                        w_dinout = 1'b1;
                        w_rin    = w_rx_oh;
                        w_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout = w_rx_oh;
                        w_ain  = 1'b1;
                    end
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    w_rout   = w_ry_oh;
                    w_gin    = 1'b1;
                    w_addsub = (w_op == OP_SUB);
                end else begin
                    // Only add/sub reach T2. Anything else returns home
                    // without raising any strobes.
                    w_done = 1'b1;
                end
            end
            T3: begin
                w_gout = 1'b1;
                w_rin  = w_rx_oh;
                w_done = 1'b1;
            end
            default: begin
                w_done = 1'b1;
            end
        endcase

        // T0 holds until a Run arrives. A Done step returns to T0.
        // Any other step advances by one.
        if (r_step == T0) begin
            w_step_next = Run ? T1 : T0;
        end else if (w_done) begin
            w_step_next = T0;
        end else begin
            w_step_next = step_t'(r_step + 2'd1);
        end

        // Reset blanks every strobe in the same cycle. This aborts an
        // instruction before it can write a register and suppresses a fetch.
        if (Reset) begin
            w_irin   = 1'b0;
            w_rin    = '0;
            w_rout   = '0;
            w_ain    = 1'b0;
            w_gin    = 1'b0;
            w_gout   = 1'b0;
            w_dinout = 1'b0;
            w_addsub = 1'b0;
            w_done   = 1'b0;
        end
    end

    assign IR     = r_ir;
    assign IRin   = w_irin;
    assign Rin    = w_rin;
    assign Rout   = w_rout;
    assign Ain    = w_ain;
    assign Gin    = w_gin;
    assign Gout   = w_gout;
    assign DINout = w_dinout;
    assign AddSub = w_addsub;
    assign Done   = w_done;

endmodule
